// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and constants for the load/store unit
package lsu_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core-to-LSU request/response bundle
interface load_store_unit_if;

  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        misaligned;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, addr, wdata,
    input  stall, rdata, misaligned
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, addr, wdata,
    output stall, rdata, misaligned
  );

endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian load extract/extend and store lane merge
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Half accesses only look at lane[1]; reserved size behaves as a word.
  always_comb begin
    sel_byte   = word[{lane, 3'b000} +: 8];
    sel_half   = lane[1] ? word[31:16] : word[15:0];
    load_val   = word;
    store_word = wdata;
    unique case (size)
      SZ_BYTE: begin
        load_val   = {{24{sel_byte[7] & ~uns}}, sel_byte};
        store_word = word;
        store_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_val   = {{16{sel_half[15] & ~uns}}, sel_half};
        store_word = lane[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      end
      default: begin
        load_val   = word;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory stage with latency stall; LSU_ALIGN_CHECK_EN enables misalignment faults
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);

  lsu_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             stall_c;
  logic             complete;
  logic             fault;
  logic             do_write;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [31:0]      ram_word;
  logic [31:0]      load_val;
  logic [31:0]      store_word;
  logic             unused_addr_hi;

  // Upper address bits wrap onto the RAM.
  assign idx            = bus.addr[IDX_W+1:2];
  assign unused_addr_hi = ^bus.addr[31:IDX_W+2];
  assign ram_word       = mem[idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = 1'b0;
    complete  = 1'b0;
    if (LATENCY == 0) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      complete  = bus.req_valid;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            stall_c   = 1'b1;
            state_nxt = BUSY;
            cnt_nxt   = CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            stall_c = 1'b1;
            cnt_nxt = cnt - 1'b1;
          end else begin
            // A dropped req_valid here means the core flushed: abort quietly.
            complete  = bus.req_valid;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    if (reset) begin
      stall_c  = 1'b0;
      complete = 1'b0;
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  assign fault = ((bus.req_size == SZ_HALF) && bus.addr[0])
              || ((bus.req_size == SZ_WORD) && (bus.addr[1:0] != 2'b00))
              || (bus.req_size == SZ_RSVD);
`else
  assign fault = 1'b0;
`endif

  lsu_lane_align u_align (
    .lane       (bus.addr[1:0]),
    .size       (bus.req_size),
    .uns        (bus.req_unsigned),
    .word       (ram_word),
    .wdata      (bus.wdata),
    .load_val   (load_val),
    .store_word (store_word)
  );

  assign do_write       = complete & bus.req_write & ~fault;
  assign bus.stall      = stall_c;
  assign bus.misaligned = complete & fault;
  assign bus.rdata      = (complete && !fault) ? load_val : 32'h0;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[idx] <= store_word;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit (LATENCY 2 and 0)
module tb_load_store_unit;
  import lsu_pkg::*;

`ifdef LSU_ALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus_l2 ();
  load_store_unit_if bus_l0 ();

  load_store_unit #(.DEPTH_WORDS(1024), .LATENCY(2)) dut_l2 (
    .clk(clk), .reset(rst), .bus(bus_l2.slave));
  load_store_unit #(.DEPTH_WORDS(1024), .LATENCY(0)) dut_l0 (
    .clk(clk), .reset(rst), .bus(bus_l0.slave));

  logic        r_valid [2];
  logic        r_write [2];
  logic [1:0]  r_size  [2];
  logic        r_uns   [2];
  logic [31:0] r_addr  [2];
  logic [31:0] r_wdata [2];
  int          age     [2];

  assign bus_l2.req_valid    = r_valid[0];
  assign bus_l2.req_write    = r_write[0];
  assign bus_l2.req_size     = r_size[0];
  assign bus_l2.req_unsigned = r_uns[0];
  assign bus_l2.addr         = r_addr[0];
  assign bus_l2.wdata        = r_wdata[0];
  assign bus_l0.req_valid    = r_valid[1];
  assign bus_l0.req_write    = r_write[1];
  assign bus_l0.req_size     = r_size[1];
  assign bus_l0.req_unsigned = r_uns[1];
  assign bus_l0.addr         = r_addr[1];
  assign bus_l0.wdata        = r_wdata[1];

  logic        d_stall [2];
  logic [31:0] d_rdata [2];
  logic        d_mis   [2];
  assign d_stall[0] = bus_l2.stall;
  assign d_rdata[0] = bus_l2.rdata;
  assign d_mis[0]   = bus_l2.misaligned;
  assign d_stall[1] = bus_l0.stall;
  assign d_rdata[1] = bus_l0.rdata;
  assign d_mis[1]   = bus_l0.misaligned;

  int checks = 0;
  int errors = 0;

  logic [31:0] mm    [2][1024];
  bit          known [2][1024];
  int          stall_seen [2];
  logic [31:0] last_rd    [2];
  logic        last_mis   [2];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int lat_of(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int idx_of(logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction

  function automatic bit fault_of(logic [31:0] a, logic [1:0] sz);
    bit raw;
    raw = (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) || (sz == 2'b11);
    return CHECK_EN && raw;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] w, logic [31:0] a, logic [1:0] sz, bit u);
    int sh;
    logic [31:0] v;
    case (sz)
      2'b00: begin
        sh = 8 * int'(a[1:0]);
        v = (w >> sh) & 32'hFF;
        if (!u && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'b01: begin
        sh = a[1] ? 16 : 0;
        v = (w >> sh) & 32'hFFFF;
        if (!u && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_merge(logic [31:0] w, logic [31:0] a, logic [1:0] sz, logic [31:0] wd);
    int sh;
    logic [31:0] mask;
    case (sz)
      2'b00: begin
        sh = 8 * int'(a[1:0]);
        mask = 32'hFF << sh;
        return (w & ~mask) | ((wd & 32'hFF) << sh);
      end
      2'b01: begin
        sh = a[1] ? 16 : 0;
        mask = 32'hFFFF << sh;
        return (w & ~mask) | ((wd & 32'hFFFF) << sh);
      end
      default: return wd;
    endcase
  endfunction

  // A request presented for `age` cycles completes when age reaches the latency.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit          exp_stall, done, flt;
      logic [31:0] exp_rd;
      int          ix;
      exp_stall = 1'b0;
      done      = 1'b0;
      flt       = 1'b0;
      exp_rd    = 32'h0;
      ix        = idx_of(r_addr[d]);
      if (!rst && r_valid[d]) begin
        exp_stall = age[d] < lat_of(d);
        done      = age[d] == lat_of(d);
      end
      if (done) begin
        flt = fault_of(r_addr[d], r_size[d]);
        if (!flt) exp_rd = model_load(mm[d][ix], r_addr[d], r_size[d], r_uns[d]);
      end
      check($sformatf("stall[%0d]", d), 32'(d_stall[d]), 32'(exp_stall));
      check($sformatf("misaligned[%0d]", d), 32'(d_mis[d]), 32'(done && flt));
      if (!done || flt || known[d][ix])
        check($sformatf("rdata[%0d]", d), d_rdata[d], exp_rd);
      if (d_stall[d]) stall_seen[d]++;
      if (done) begin
        last_rd[d]  = d_rdata[d];
        last_mis[d] = d_mis[d];
        if (r_write[d] && !flt) begin
          mm[d][ix] = model_merge(mm[d][ix], r_addr[d], r_size[d], r_wdata[d]);
          if (r_size[d][1]) known[d][ix] = 1'b1;
        end
      end
    end
  end

  task automatic access(int d, bit w, logic [1:0] sz, bit u, logic [31:0] a,
                        logic [31:0] wd, bit flush);
    r_write[d] = w;
    r_size[d]  = sz;
    r_uns[d]   = u;
    r_addr[d]  = a;
    r_wdata[d] = wd;
    r_valid[d] = 1'b1;
    age[d]     = 0;
    stall_seen[d] = 0;
    for (int i = 0; i <= lat_of(d); i++) begin
      if (flush && i == lat_of(d)) r_valid[d] = 1'b0;
      @(posedge clk);
      #1;
      age[d]++;
    end
    r_valid[d] = 1'b0;
  endtask

  logic [31:0] old_w;

  initial begin
    for (int d = 0; d < 2; d++) begin
      r_valid[d] = 1'b0; r_write[d] = 1'b0; r_size[d] = 2'b00; r_uns[d] = 1'b0;
      r_addr[d] = 32'h0; r_wdata[d] = 32'h0; age[d] = 0; stall_seen[d] = 0;
      last_rd[d] = 32'h0; last_mis[d] = 1'b0;
      for (int i = 0; i < 1024; i++) begin
        known[d][i] = 1'b0;
        mm[d][i] = 32'h0;
      end
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 64; i++) begin
      access(0, 1'b1, SZ_WORD, 1'b0, 32'(i * 4), $urandom, 1'b0);
      access(1, 1'b1, SZ_WORD, 1'b0, 32'(i * 4), $urandom, 1'b0);
    end

    access(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    check("sw_stall_cycles", 32'(stall_seen[0]), 32'd2);
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0);
    check("lw_stall_cycles", 32'(stall_seen[0]), 32'd2);
    check("lw_0x10", last_rd[0], 32'hDEADBEEF);

    access(0, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h80FF7F01, 1'b0);
    access(0, 1'b0, SZ_BYTE, 1'b0, 32'h23, 32'h0, 1'b0);
    check("lb_0x23", last_rd[0], 32'hFFFFFF80);
    access(0, 1'b0, SZ_BYTE, 1'b1, 32'h23, 32'h0, 1'b0);
    check("lbu_0x23", last_rd[0], 32'h00000080);
    access(0, 1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, 1'b0);
    check("lh_0x22", last_rd[0], 32'hFFFF80FF);
    access(0, 1'b0, SZ_HALF, 1'b1, 32'h20, 32'h0, 1'b0);
    check("lhu_0x20", last_rd[0], 32'h00007F01);

    access(0, 1'b1, SZ_WORD, 1'b0, 32'h30, 32'h11223344, 1'b0);
    access(0, 1'b1, SZ_BYTE, 1'b0, 32'h31, 32'h123456AA, 1'b0);
    access(0, 1'b1, SZ_HALF, 1'b0, 32'h32, 32'h9999BBCC, 1'b0);
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 1'b0);
    check("merge_0x30", last_rd[0], 32'hBBCCAA44);

    access(0, 1'b0, SZ_WORD, 1'b0, 32'h31, 32'h0, 1'b0);
    access(0, 1'b1, SZ_WORD, 1'b0, 32'h33, 32'h55555555, 1'b0);
`ifdef LSU_ALIGN_CHECK_EN
    check("lw_0x31_mis", 32'(last_mis[0]), 32'd1);
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 1'b0);
    check("sw_0x33_blocked", last_rd[0], 32'hBBCCAA44);
`else
    check("lw_0x31_nomis", 32'(last_mis[0]), 32'd0);
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 1'b0);
    check("sw_0x33_aligned", last_rd[0], 32'h55555555);
`endif

    old_w = mm[0][idx_of(32'h44)];
    access(0, 1'b1, SZ_WORD, 1'b0, 32'h44, ~old_w, 1'b1);
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h44, 32'h0, 1'b0);
    check("flush_no_write", last_rd[0], old_w);

    // Reset lands in the completion cycle of a pending store.
    old_w = mm[0][idx_of(32'h40)];
    r_write[0] = 1'b1; r_size[0] = SZ_WORD; r_uns[0] = 1'b0;
    r_addr[0] = 32'h40; r_wdata[0] = 32'h12345678; r_valid[0] = 1'b1; age[0] = 0;
    @(posedge clk); #1 age[0] = 1;
    @(posedge clk); #1 age[0] = 2; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; r_valid[0] = 1'b0; age[0] = 0;
    @(negedge clk);
    check("stall_after_reset", 32'(bus_l2.stall), 32'd0);
    @(posedge clk); #1;
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 1'b0);
    check("reset_discard_store", last_rd[0], old_w);
    check("post_reset_stall_cycles", 32'(stall_seen[0]), 32'd2);

    for (int n = 0; n < 150; n++) begin
      access(0, 1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2),
             32'(($urandom % 64) * 4 + ($urandom % 4)), $urandom, ($urandom % 8) == 0);
    end

    access(1, 1'b1, SZ_WORD, 1'b0, 32'h1000, 32'hCAFEF00D, 1'b0);
    check("l0_sw_stall", 32'(stall_seen[1]), 32'd0);
    access(1, 1'b0, SZ_WORD, 1'b0, 32'h0000, 32'h0, 1'b0);
    check("l0_wrap_lw", last_rd[1], 32'hCAFEF00D);
    check("l0_lw_stall", 32'(stall_seen[1]), 32'd0);

    for (int n = 0; n < 120; n++) begin
      access(1, 1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2),
             ($urandom & 32'hFFFF_F000) | 32'(($urandom % 64) * 4 + ($urandom % 4)),
             $urandom, 1'b0);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
